// File: rtl/sdrahb_ram_arb.sv
// Read/write access arbiter for the SDRAHB dual-port ECC RAM: two requesters,
// independent round-robin read and write pools, and write-wins collision handling.
module sdrahb_ram_arb #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  a_gnt,
  output logic                  b_gnt,
  output logic                  a_rvalid,
  output logic                  b_rvalid,
  output logic [DATA_WIDTH-1:0] a_rdata,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic                  ram_wr_en,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  output logic [DATA_WIDTH-1:0] ram_data_in,
  input  logic [DATA_WIDTH-1:0] ram_data_out
);

  typedef enum logic {REQ_A = 1'b0, REQ_B = 1'b1} req_id_e;

  req_id_e rd_last_q, rd_last_d;
  req_id_e wr_last_q, wr_last_d;
  req_id_e rd_owner_q, rd_owner_d;
  logic    rd_pend_q, rd_pend_d;

  logic    a_wr, b_wr, a_rd, b_rd;
  logic    wr_go, rd_go, collide;
  req_id_e wr_win, rd_win;

  assign a_wr = a_req & a_we;
  assign b_wr = b_req & b_we;
  assign a_rd = a_req & ~a_we;
  assign b_rd = b_req & ~b_we;

  // Write pool is resolved first; the read pool depends on its result.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    wr_go       = 1'b0;
    wr_win      = REQ_A;
    wr_last_d   = wr_last_q;
    ram_wr_addr = a_addr;
    ram_data_in = a_wdata;
    if (!rst && (a_wr || b_wr)) begin
      wr_go = 1'b1;
      if (a_wr && b_wr) begin
        wr_win = (wr_last_q == REQ_A) ? REQ_B : REQ_A;
      end else begin
        wr_win = a_wr ? REQ_A : REQ_B;
      end
      wr_last_d = wr_win;
    end
    if (wr_win == REQ_B) begin
      ram_wr_addr = b_addr;
      ram_data_in = b_wdata;
    end
  end

  // A read hitting the address being written this cycle waits one cycle so it sees new data.
  always_comb begin
    rd_win = REQ_A;
    if (a_rd && b_rd) begin
      rd_win = (rd_last_q == REQ_A) ? REQ_B : REQ_A;
    end else if (b_rd) begin
      rd_win = REQ_B;
    end
    ram_rd_addr = (rd_win == REQ_B) ? b_addr : a_addr;
    collide     = wr_go && (ram_rd_addr == ram_wr_addr);
    rd_go       = !rst && (a_rd || b_rd) && !collide;
    rd_last_d   = rd_go ? rd_win : rd_last_q;
    rd_owner_d  = rd_go ? rd_win : rd_owner_q;
    rd_pend_d   = rd_go;
  end

  always_ff @(posedge clk) begin
    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      rd_last_q  <= REQ_B;
      wr_last_q  <= REQ_B;
      rd_owner_q <= REQ_A;
      rd_pend_q  <= 1'b0;
    end else begin
      rd_last_q  <= rd_last_d;
      wr_last_q  <= wr_last_d;
      rd_owner_q <= rd_owner_d;
      rd_pend_q  <= rd_pend_d;
    end
  end

  assign a_gnt     = (wr_go && wr_win == REQ_A) || (rd_go && rd_win == REQ_A);
  assign b_gnt     = (wr_go && wr_win == REQ_B) || (rd_go && rd_win == REQ_B);
  assign ram_wr_en = wr_go;

  // Gating with rst drops a read granted just before reset asserts.
  assign a_rvalid = rd_pend_q && (rd_owner_q == REQ_A) && !rst;
  assign b_rvalid = rd_pend_q && (rd_owner_q == REQ_B) && !rst;
  assign a_rdata  = ram_data_out;
  assign b_rdata  = ram_data_out;

endmodule
